tune_player: RTL and testbench

TUNE_PLAYER -- requirements
Module: tune_player

---
 rtl/tune_pkg.sv | 48 ++++
 rtl/tune_rom.sv | 31 +++
 rtl/tune_player.sv | 127 ++++++++++++
 tb/tb_tune_player.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tune_pkg.sv
// rtl/tune_pkg.sv - shared types, note constants and duration limits for the tune player
package tune_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } state_t;

   localparam int NOTE_W = 16;
   localparam int LIM_W  = 25;

   localparam logic [NOTE_W-1:0] HP_REST = 16'd0;
   localparam logic [NOTE_W-1:0] HP_G6   = 16'd15944;
   localparam logic [NOTE_W-1:0] HP_C7   = 16'd11950;
   localparam logic [NOTE_W-1:0] HP_E7   = 16'd9480;
   localparam logic [NOTE_W-1:0] HP_G7   = 16'd7972;

   localparam logic [LIM_W-1:0] DUR_LIM_0 = 25'h040_0000;
   localparam logic [LIM_W-1:0] DUR_LIM_1 = 25'h080_0000;
   localparam logic [LIM_W-1:0] DUR_LIM_2 = 25'h0C0_0000;
   localparam logic [LIM_W-1:0] DUR_LIM_3 = 25'h100_0000;

   typedef struct packed {
      logic [NOTE_W-1:0] half_period;
      logic [1:0]        dur_code;
      logic              last;
   } rom_entry_t;

   function automatic logic [LIM_W-1:0] dur_limit(input logic [1:0] code);
      case (code)
         2'd0:    return DUR_LIM_0;
         2'd1:    return DUR_LIM_1;
         2'd2:    return DUR_LIM_2;
         default: return DUR_LIM_3;
      endcase
   endfunction

   function automatic rom_entry_t note(input logic [NOTE_W-1:0] hp, input logic [1:0] code,
                                       input logic last);
      rom_entry_t e;
      e.half_period = hp;
      e.dur_code    = code;
      e.last        = last;
      return e;
   endfunction

endpackage

// File: rtl/tune_rom.sv
// rtl/tune_rom.sv - combinational note table indexed by tune and note index
module tune_rom
   import tune_pkg::*;
(
   input  logic [1:0] tune_sel,
   input  logic [2:0] index,
   output rom_entry_t entry
);

   // Unused slots read as a terminating rest so a bad address cannot run away.
   always_comb begin
      entry = note(HP_REST, 2'd0, 1'b1);
      case ({tune_sel, index})
         5'b00_000: entry = note(HP_G6,   2'd1, 1'b0);
         5'b00_001: entry = note(HP_C7,   2'd1, 1'b0);
         5'b00_010: entry = note(HP_E7,   2'd1, 1'b0);
         5'b00_011: entry = note(HP_G7,   2'd2, 1'b0);
         5'b00_100: entry = note(HP_E7,   2'd0, 1'b0);
         5'b00_101: entry = note(HP_G7,   2'd2, 1'b1);
         5'b01_000: entry = note(HP_G6,   2'd1, 1'b0);
         5'b01_001: entry = note(HP_REST, 2'd0, 1'b0);
         5'b01_010: entry = note(HP_G6,   2'd1, 1'b1);
         5'b10_000: entry = note(HP_C7,   2'd0, 1'b0);
         5'b10_001: entry = note(HP_E7,   2'd0, 1'b0);
         5'b10_010: entry = note(HP_G7,   2'd1, 1'b1);
         5'b11_000: entry = note(HP_REST, 2'd0, 1'b1);
         default:   entry = note(HP_REST, 2'd0, 1'b1);
      endcase
   end

endmodule

// File: rtl/tune_player.sv
// rtl/tune_player.sv - piezo tune sequencer with tone generator and note duration timer
module tune_player
   import tune_pkg::*;
#(
   parameter int FAST_SIM = 1,
   parameter int HP_W     = 16,
   parameter int DUR_W    = 26
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic [1:0] tune_sel,
   input  logic       stop,
   output logic       piezo,
   output logic       piezo_n,
   output logic       busy,
   output logic       done
);

   localparam logic [DUR_W-1:0] STEP = (FAST_SIM != 0) ? DUR_W'(16) : DUR_W'(1);

   state_t            state, state_nxt;
   logic              start, load, advance, finish, note_end;
   logic [1:0]        sel_q;
   logic [2:0]        idx_q;
   logic [HP_W-1:0]   hp_q, tone_cnt;
   logic [1:0]        code_q;
   logic              last_q;
   logic [DUR_W-1:0]  dur_cnt;
   rom_entry_t        entry;

   tune_rom u_rom (
      .tune_sel (sel_q),
      .index    (idx_q),
      .entry    (entry)
   );

   assign note_end = (dur_cnt >= DUR_W'(dur_limit(code_q)));
   assign busy     = (state != ST_IDLE);
   assign piezo_n  = ~piezo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // stop outranks both a new go and a natural note end
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (go && !stop) begin
               state_nxt = ST_LOAD;
               start     = 1'b1;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_PLAY;
               load      = 1'b1;
            end
         end
         ST_PLAY: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (note_end) begin
               if (last_q) begin
                  state_nxt = ST_IDLE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = ST_LOAD;
                  advance   = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         idx_q    <= '0;
         hp_q     <= '0;
         code_q   <= '0;
         last_q   <= 1'b0;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         piezo    <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= finish;
         if (start) begin
            sel_q <= tune_sel;
            idx_q <= '0;
         end
         if (advance) idx_q <= idx_q + 3'd1;
         if (load) begin
            hp_q     <= HP_W'(entry.half_period);
            code_q   <= entry.dur_code;
            last_q   <= entry.last;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            piezo    <= (entry.half_period != '0);
         end else if (state == ST_PLAY && state_nxt == ST_PLAY) begin
            dur_cnt <= dur_cnt + STEP;
            if (hp_q == '0) begin
               piezo <= 1'b0;
            end else if (tone_cnt == hp_q - HP_W'(1)) begin
               tone_cnt <= '0;
               piezo    <= ~piezo;
            end else begin
               tone_cnt <= tone_cnt + HP_W'(1);
            end
         end else begin
            piezo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tune_player.sv
// tb/tb_tune_player.sv - randomized self-checking bench for tune_player against a note-table model
module tb_tune_player;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       go = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] tune_sel = 2'd0;
   logic       piezo, piezo_n, busy, done;

   int vectors = 0;
   int miscompares = 0;

   int hp_tab [4][8];
   int dur_tab [4][8];
   int len_tab [4];
   logic [25:0] force_val;

   tune_player #(.FAST_SIM(1), .HP_W(16), .DUR_W(26)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (go),
      .tune_sel (tune_sel),
      .stop     (stop),
      .piezo    (piezo),
      .piezo_n  (piezo_n),
      .busy     (busy),
      .done     (done)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic p, input logic b, input logic d);
      check_eq(tag, 32'({piezo, piezo_n, busy, done}), 32'({p, ~p, b, d}));
   endtask

   // Half-periods in cycles and note lengths in cycles at a step of 16.
   task automatic set_note(input int t, input int n, input int hp, input int dur);
      hp_tab[t][n]  = hp;
      dur_tab[t][n] = dur;
      len_tab[t]    = n + 1;
   endtask

   task automatic init_tables();
      set_note(0, 0, 15944, 524288);
      set_note(0, 1, 11950, 524288);
      set_note(0, 2, 9480,  524288);
      set_note(0, 3, 7972,  786432);
      set_note(0, 4, 9480,  262144);
      set_note(0, 5, 7972,  786432);
      set_note(1, 0, 15944, 524288);
      set_note(1, 1, 0,     262144);
      set_note(1, 2, 15944, 524288);
      set_note(2, 0, 11950, 262144);
      set_note(2, 1, 9480,  262144);
      set_note(2, 2, 7972,  524288);
      set_note(3, 0, 0,     262144);
   endtask

   function automatic logic model_piezo(input int hp, input int i);
      return (hp != 0) && ((i / hp) % 2 == 0);
   endfunction

   task automatic jitter();
      go       = 1'($urandom_range(0, 1));
      tune_sel = 2'($urandom);
   endtask

   // Each note is played for j+2 cycles: the duration counter is pushed to one step
   // below its limit, then to the limit, so the note must end on exactly that edge.
   task automatic play_tune(input int t, input int stop_note, input int long_j);
      int j, hp, prev, nrise, rise0, rise1;
      logic [25:0] lim;
      tune_sel = 2'(t);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int n = 0; n < len_tab[t]; n++) begin
         hp  = hp_tab[t][n];
         lim = 26'(dur_tab[t][n] * 16);
         j   = (long_j > 0 && n == 0) ? long_j : int'($urandom_range(2, 40));
         check_out("load", 1'b0, 1'b1, 1'b0);
         jitter();
         @(negedge clk);
         prev = 0; nrise = 0; rise0 = 0; rise1 = 0;
         for (int i = 0; i <= j + 1; i++) begin
            check_out("play", model_piezo(hp, i), 1'b1, 1'b0);
            if (piezo === 1'b1 && prev == 0) begin
               if (nrise == 0) rise0 = i;
               else if (nrise == 1) rise1 = i;
               nrise++;
            end
            prev = (piezo === 1'b1) ? 1 : 0;
            if (n == stop_note && i == j) begin
               stop = 1'b1;
               go   = 1'b0;
               @(negedge clk);
               stop = 1'b0;
               for (int k = 0; k < 3; k++) begin
                  check_out("stopped", 1'b0, 1'b0, 1'b0);
                  @(negedge clk);
               end
               return;
            end
            if (i == j) begin
               force_val = lim - 26'd16;
               force dut.dur_cnt = force_val;
            end else if (i == j + 1) begin
               force_val = lim;
               force dut.dur_cnt = force_val;
            end
            jitter();
            @(negedge clk);
         end
         release dut.dur_cnt;
         go = 1'b0;
         if (long_j > 0 && n == 0) check_eq("tone_period", 32'(rise1 - rise0), 32'(2 * hp));
      end
      check_out("done", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check_out("idle_after_done", 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int t, sn;
      init_tables();
      repeat (3) @(negedge clk);
      check_out("reset", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_out("post_reset", 1'b0, 1'b0, 1'b0);

      go = 1'b1; stop = 1'b1; tune_sel = 2'd2;
      @(negedge clk);
      check_out("go_stop", 1'b0, 1'b0, 1'b0);
      go = 1'b0; stop = 1'b0;
      @(negedge clk);
      check_out("go_stop_hold", 1'b0, 1'b0, 1'b0);

      play_tune(2, -1, 24000);
      play_tune(0, -1, 0);
      play_tune(1, -1, 0);
      play_tune(3, -1, 0);
      play_tune(0, 3, 0);
      play_tune(0, -1, 0);

      for (int r = 0; r < 10; r++) begin
         t  = int'($urandom_range(0, 3));
         sn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len_tab[t] - 1)) : -1;
         play_tune(t, sn, 0);
      end

      tune_sel = 2'd0; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (10) @(negedge clk);
      check_out("pre_reset_tone", 1'b1, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1 check_out("async_reset", 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check_out("reset_hold", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_out("wait_go", 1'b0, 1'b0, 1'b0);
      end
      play_tune(2, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
